// File: rtl/timer_pkg.sv
// Purpose : shared constants and FSM state encoding for the timer sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

  // Default counter / register width.
  localparam int CW_DEF     = 16;

  // Period value loaded by reset; never zero so period_reg-1 cannot underflow.
  localparam int PERIOD_RST = 1;

  // Encoding 2'd3 is unused and falls back to ST_IDLE in the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tsc_shadow_regs.sv
// Purpose : shadow copy of the cfg_* fields plus the active (applied) copy.
// Latency : cfg_wr -> shadow/upd_pend 1 edge; apply -> active regs 1 edge.
// Backpressure: none; a write while upd_pend=1 overwrites the shadow (last wins).
//
// Ports:
//   slow_clk, rst (async, active-high), sw_rst (sync, active-high)
//   cfg_wr/cfg_*   : configuration strobe and fields
//   apply          : move shadow into active regs (asserted only with upd_pend)
//   period_reg, duty_reg, mode, timer_mode, act_en : active configuration
//   sh_en          : enable bit held in the shadow (FSM looks ahead with it)
//   upd_pend       : shadow holds a not-yet-applied write
//   cfg_err        : one-cycle pulse for a rejected (period == 0) write
module tsc_shadow_regs
  import timer_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          slow_clk,
  input  logic          rst,
  input  logic          sw_rst,
  input  logic          cfg_wr,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_duty,
  input  logic          cfg_mode,
  input  logic          cfg_tmode,
  input  logic          cfg_en,
  input  logic          apply,
  output logic [CW-1:0] period_reg,
  output logic [CW-1:0] duty_reg,
  output logic          mode,
  output logic          timer_mode,
  output logic          act_en,
  output logic          sh_en,
  output logic          upd_pend,
  output logic          cfg_err
);

  logic [CW-1:0] sh_period;
  logic [CW-1:0] sh_duty;
  logic          sh_mode;
  logic          sh_tmode;
  logic          wr_ok;
  logic          wr_bad;

  assign wr_ok  = cfg_wr && (cfg_period != '0);
  assign wr_bad = cfg_wr && (cfg_period == '0);

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      sh_period  <= CW'(PERIOD_RST);
      sh_duty    <= '0;
      sh_mode    <= 1'b0;
      sh_tmode   <= 1'b0;
      sh_en      <= 1'b0;
      period_reg <= CW'(PERIOD_RST);
      duty_reg   <= '0;
      mode       <= 1'b0;
      timer_mode <= 1'b0;
      act_en     <= 1'b0;
      upd_pend   <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (sw_rst) begin
      sh_period  <= CW'(PERIOD_RST);
      sh_duty    <= '0;
      sh_mode    <= 1'b0;
      sh_tmode   <= 1'b0;
      sh_en      <= 1'b0;
      period_reg <= CW'(PERIOD_RST);
      duty_reg   <= '0;
      mode       <= 1'b0;
      timer_mode <= 1'b0;
      act_en     <= 1'b0;
      upd_pend   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= wr_bad;
      if (wr_ok) begin
        sh_period <= cfg_period;
        sh_duty   <= cfg_duty;
        sh_mode   <= cfg_mode;
        sh_tmode  <= cfg_tmode;
        sh_en     <= cfg_en;
      end
      // Apply takes the shadow as it stood before this edge.
      if (apply) begin
        period_reg <= sh_period;
        duty_reg   <= sh_duty;
        mode       <= sh_mode;
        timer_mode <= sh_tmode;
        act_en     <= sh_en;
      end
      // A write landing on the apply edge leaves a fresh update pending.
      if (wr_ok) begin
        upd_pend <= 1'b1;
      end else if (apply) begin
        upd_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Purpose : sequencing FSM for a PWM/timer counter: config apply points, run enable, irq.
// Latency : all outputs registered (counter_en decodes the state register); 1 edge from cause.
// Backpressure: none; config writes are staged and applied only at safe points.
//
// Optional feature macro: TSC_IRQ_OVERRUN_EN adds irq_ovr[7:0], a saturating
// count of irq set events that found irq already high; cleared by irq_ack.
//
// Ports:
//   slow_clk, rst (async, active-high), sw_rst (sync, active-high)
//   cfg_wr, cfg_period, cfg_duty, cfg_mode, cfg_tmode, cfg_en : configuration write
//   counter, irq_ack                                          : status inputs
//   period_reg, duty_reg, counter_en, mode, timer_mode         : active configuration
//   irq_rst, irq, upd_pend, cfg_err, state [, irq_ovr]         : status outputs
module timer_seq_ctrl
  import timer_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          slow_clk,
  input  logic          rst,
  input  logic          sw_rst,
  input  logic          cfg_wr,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_duty,
  input  logic          cfg_mode,
  input  logic          cfg_tmode,
  input  logic          cfg_en,
  input  logic [CW-1:0] counter,
  input  logic          irq_ack,
  output logic [CW-1:0] period_reg,
  output logic [CW-1:0] duty_reg,
  output logic          counter_en,
  output logic          mode,
  output logic          timer_mode,
  output logic          irq_rst,
  output logic          irq,
  output logic          upd_pend,
  output logic          cfg_err,
  output logic [1:0]    state
`ifdef TSC_IRQ_OVERRUN_EN
  ,
  output logic [7:0]    irq_ovr
`endif
);

  state_t state_q;
  state_t state_d;
  logic   boundary;
  logic   apply;
  logic   irq_set;
  logic   act_en;
  logic   sh_en;

  tsc_shadow_regs #(.CW(CW)) u_shadow (
    .slow_clk   (slow_clk),
    .rst        (rst),
    .sw_rst     (sw_rst),
    .cfg_wr     (cfg_wr),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_mode   (cfg_mode),
    .cfg_tmode  (cfg_tmode),
    .cfg_en     (cfg_en),
    .apply      (apply),
    .period_reg (period_reg),
    .duty_reg   (duty_reg),
    .mode       (mode),
    .timer_mode (timer_mode),
    .act_en     (act_en),
    .sh_en      (sh_en),
    .upd_pend   (upd_pend),
    .cfg_err    (cfg_err)
  );

  // End of a period: PWM wraps at period-1, timer fires once it reaches period.
  // period_reg is never zero, so the subtraction cannot wrap.
  assign boundary = mode ? (counter == (period_reg - CW'(1)))
                         : (counter >= period_reg);

  always_comb begin
    state_d    = state_q;
    apply      = 1'b0;
    irq_set    = 1'b0;
    counter_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Decide on the enable that will be active after this edge.
        apply = upd_pend;
        if (upd_pend ? sh_en : act_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        counter_en = 1'b1;
        if (boundary) begin
          apply   = upd_pend;
          irq_set = ~mode;
          if (!act_en) begin
            state_d = ST_IDLE;
          end else if (!mode && !timer_mode) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Parked after a one-shot until software supplies a new config.
        if (upd_pend) begin
          apply   = 1'b1;
          state_d = sh_en ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      irq     <= 1'b0;
      irq_rst <= 1'b1;
    end else if (sw_rst) begin
      state_q <= ST_IDLE;
      irq     <= 1'b0;
      irq_rst <= 1'b1;
    end else begin
      state_q <= state_d;
      // A set on the ack edge wins so the new event is not lost.
      irq     <= irq_set | (irq & ~irq_ack);
      irq_rst <= ~irq_ack;
    end
  end

  assign state = state_q;

`ifdef TSC_IRQ_OVERRUN_EN
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      irq_ovr <= '0;
    end else if (sw_rst) begin
      irq_ovr <= '0;
    end else if (irq_ack) begin
      // Ack coinciding with a set consumes that set: count is left as is.
      if (!irq_set) begin
        irq_ovr <= '0;
      end
    end else if (irq_set && irq && (irq_ovr != 8'hFF)) begin
      irq_ovr <= irq_ovr + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_timer_seq_ctrl.sv
module tb_timer_seq_ctrl;

  localparam int CW = 16;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic          slow_clk = 1'b0;
  logic          rst, sw_rst, cfg_wr, cfg_mode, cfg_tmode, cfg_en, irq_ack;
  logic [CW-1:0] cfg_period, cfg_duty, counter;
  logic [CW-1:0] period_reg, duty_reg;
  logic          counter_en, mode, timer_mode, irq_rst, irq, upd_pend, cfg_err;
  logic [1:0]    state;
`ifdef TSC_IRQ_OVERRUN_EN
  logic [7:0]    irq_ovr;
`endif

  timer_seq_ctrl #(.CW(CW)) dut (
    .slow_clk   (slow_clk),
    .rst        (rst),
    .sw_rst     (sw_rst),
    .cfg_wr     (cfg_wr),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_mode   (cfg_mode),
    .cfg_tmode  (cfg_tmode),
    .cfg_en     (cfg_en),
    .counter    (counter),
    .irq_ack    (irq_ack),
    .period_reg (period_reg),
    .duty_reg   (duty_reg),
    .counter_en (counter_en),
    .mode       (mode),
    .timer_mode (timer_mode),
    .irq_rst    (irq_rst),
    .irq        (irq),
    .upd_pend   (upd_pend),
    .cfg_err    (cfg_err),
    .state      (state)
`ifdef TSC_IRQ_OVERRUN_EN
    ,
    .irq_ovr    (irq_ovr)
`endif
  );

  always #5 slow_clk = ~slow_clk;

  // Reference model: a configuration record, a staged copy and a few flags.
  typedef struct {
    int unsigned period;
    int unsigned duty;
    bit          mode;
    bit          tmode;
    bit          en;
  } cfg_s;

  cfg_s        act, shd;
  bit          pend, m_irq, m_irq_rst, m_err;
  int          m_state;
  int unsigned m_cnt;
  int          m_ovr;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic void model_reset();
    act = '{period: 1, duty: 0, mode: 1'b0, tmode: 1'b0, en: 1'b0};
    shd = act;
    pend = 1'b0; m_irq = 1'b0; m_irq_rst = 1'b1; m_err = 1'b0;
    m_state = S_IDLE; m_cnt = 0; m_ovr = 0;
  endfunction

  // True when the current counter value closes the active period.
  function automatic bit ends_now();
    if (act.mode) return int'(counter) == int'(act.period) - 1;
    return int'(counter) >= int'(act.period);
  endfunction

  // One clock edge of the reference behaviour, using the inputs as driven now.
  function automatic void model_edge();
    bit          fin, take, fire, good_wr;
    int          next;
    int unsigned cnt;
    if (sw_rst) begin
      model_reset();
      return;
    end
    fin = ends_now();
    good_wr = cfg_wr && (cfg_period != 0);
    cnt = (m_state == S_RUN) ? (fin ? 0 : int'(counter) + 1) : 0;
    take = 1'b0; fire = 1'b0; next = m_state;
    if (m_state == S_IDLE) begin
      take = pend;
      if (pend ? shd.en : act.en) next = S_RUN;
    end else if (m_state == S_RUN) begin
      if (fin) begin
        take = pend;
        fire = !act.mode;
        if (!act.en) next = S_IDLE;
        else if (!act.mode && !act.tmode) next = S_DONE;
      end
    end else begin
      if (pend) begin
        take = 1'b1;
        next = shd.en ? S_RUN : S_IDLE;
      end
    end
    if (irq_ack) begin
      if (!fire) m_ovr = 0;
    end else if (fire && m_irq && m_ovr < 255) begin
      m_ovr++;
    end
    m_irq     = fire || (m_irq && !irq_ack);
    m_irq_rst = !irq_ack;
    m_err     = cfg_wr && (cfg_period == 0);
    if (take) begin
      act  = shd;
      pend = 1'b0;
    end
    if (good_wr) begin
      shd = '{period: cfg_period, duty: cfg_duty, mode: cfg_mode, tmode: cfg_tmode, en: cfg_en};
      pend = 1'b1;
    end
    m_state = next;
    m_cnt = cnt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},      state,      m_state);
    chk({tag, ".period_reg"}, period_reg, act.period);
    chk({tag, ".duty_reg"},   duty_reg,   act.duty);
    chk({tag, ".counter_en"}, counter_en, m_state == S_RUN);
    chk({tag, ".mode"},       mode,       act.mode);
    chk({tag, ".timer_mode"}, timer_mode, act.tmode);
    chk({tag, ".irq"},        irq,        m_irq);
    chk({tag, ".irq_rst"},    irq_rst,    m_irq_rst);
    chk({tag, ".upd_pend"},   upd_pend,   pend);
    chk({tag, ".cfg_err"},    cfg_err,    m_err);
`ifdef TSC_IRQ_OVERRUN_EN
    chk({tag, ".irq_ovr"},    irq_ovr,    m_ovr);
`endif
  endtask

  task automatic tick(input string tag);
    if (rst) model_reset();
    else model_edge();
    @(posedge slow_clk);
    #1;
    counter = CW'(m_cnt);
    check_all(tag);
  endtask

  task automatic write_cfg(input int per, input int dty, input bit md, input bit tm, input bit en);
    cfg_wr = 1'b1; cfg_period = CW'(per); cfg_duty = CW'(dty);
    cfg_mode = md; cfg_tmode = tm; cfg_en = en;
    tick("wr");
    cfg_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw_rst = 1'b0; cfg_wr = 1'b0; cfg_mode = 1'b0; cfg_tmode = 1'b0;
    cfg_en = 1'b0; irq_ack = 1'b0; cfg_period = '0; cfg_duty = '0; counter = '0;
    model_reset();

    // Reset values
    #3;
    check_all("rst");
    chk("rst_period", period_reg, 1);
    chk("rst_irq_rst", irq_rst, 1);
    tick("rst_hold");
    rst = 1'b0;

    // PWM period update lands only on the wrap edge
    write_cfg(10, 4, 1'b1, 1'b1, 1'b1);
    chk("pwm_pend0", upd_pend, 1);
    tick("pwm_start");
    chk("pwm_run", state, S_RUN);
    for (int i = 0; i < 20 && counter != 3; i++) tick("pwm_to3");
    chk("pwm_at3", counter, 3);
    write_cfg(20, 4, 1'b1, 1'b1, 1'b1);
    chk("pwm_pend1", upd_pend, 1);
    for (int i = 0; i < 20 && counter != 9; i++) begin
      tick("pwm_hold");
      chk("pwm_hold_period", period_reg, 10);
    end
    tick("pwm_wrap");
    chk("pwm_new_period", period_reg, 20);
    chk("pwm_pend_clr", upd_pend, 0);

    // Disable at the next boundary
    write_cfg(10, 4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && m_state != S_IDLE; i++) tick("stop");
    chk("stop_state", state, S_IDLE);
    chk("stop_cnt_en", counter_en, 0);

    // One-shot timer
    write_cfg(5, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && m_state != S_DONE; i++) tick("oneshot");
    chk("os_irq", irq, 1);
    chk("os_state", state, S_DONE);
    chk("os_cnt_en", counter_en, 0);
    irq_ack = 1'b1;
    tick("os_ack");
    irq_ack = 1'b0;
    chk("os_irq_clr", irq, 0);
    chk("os_irq_rst_lo", irq_rst, 0);
    tick("os_after");
    chk("os_irq_rst_hi", irq_rst, 1);

    // Rejected write
    write_cfg(0, 7, 1'b1, 1'b1, 1'b1);
    chk("rej_err", cfg_err, 1);
    chk("rej_period", period_reg, 5);
    chk("rej_pend", upd_pend, 0);
    tick("rej_after");
    chk("rej_err_pulse", cfg_err, 0);

    // Ack on the same edge as a new irq set
    write_cfg(3, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !m_irq; i++) tick("sim_first");
    chk("sim_irq1", irq, 1);
    for (int i = 0; i < 20 && !(m_state == S_RUN && ends_now()); i++) tick("sim_wait");
    irq_ack = 1'b1;
    tick("sim_ack");
    irq_ack = 1'b0;
    chk("sim_irq_kept", irq, 1);
`ifdef TSC_IRQ_OVERRUN_EN
    chk("sim_ovr0", irq_ovr, 0);
`endif
    for (int i = 0; i < 20 && !(m_state == S_RUN && ends_now()); i++) tick("sim_wait2");
    tick("sim_second");
    chk("sim_irq2", irq, 1);
`ifdef TSC_IRQ_OVERRUN_EN
    chk("sim_ovr1", irq_ovr, 1);
`endif

    // Async reset while running with an update pending
    write_cfg(7, 2, 1'b0, 1'b1, 1'b1);
    chk("ar_pend", upd_pend, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("ar");
    chk("ar_state", state, S_IDLE);
    chk("ar_irq", irq, 0);
    chk("ar_pend_clr", upd_pend, 0);
    tick("ar_hold");
    rst = 1'b0;

    // Sync reset, same situation
    write_cfg(3, 1, 1'b0, 1'b1, 1'b1);
    tick("sr_start");
    tick("sr_run");
    write_cfg(6, 1, 1'b1, 1'b1, 1'b1);
    chk("sr_pend", upd_pend, 1);
    sw_rst = 1'b1;
    tick("sr");
    sw_rst = 1'b0;
    chk("sr_state", state, S_IDLE);
    chk("sr_period", period_reg, 1);
    chk("sr_pend_clr", upd_pend, 0);
    chk("sr_cnt_en", counter_en, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      cfg_wr     = ($urandom_range(5) == 0);
      cfg_period = CW'($urandom_range(6));
      cfg_duty   = CW'($urandom_range(255));
      cfg_mode   = 1'($urandom_range(1));
      cfg_tmode  = 1'($urandom_range(1));
      cfg_en     = ($urandom_range(3) != 0);
      irq_ack    = ($urandom_range(7) == 0);
      sw_rst     = ($urandom_range(149) == 0);
      if ($urandom_range(19) == 0) counter = CW'($urandom_range(8));
      tick("rnd");
    end
    cfg_wr = 1'b0; irq_ack = 1'b0; sw_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_seq_ctrl.md
TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 SHALL have parameter CW, default 16, counter/register width.
REQ-002 SHALL have ports, clock and reset first:
- slow_clk  in  1  +ve edge clock shared with main counter
- rst  in  1  asynchronous active-high reset
- sw_rst  in  1  synchronous active-high software reset
- cfg_wr  in  1  one-cycle strobe; capture cfg_* inputs
- cfg_period  in  CW  requested period
- cfg_duty  in  CW  requested duty
- cfg_mode  in  1  1=PWM, 0=timer
- cfg_tmode  in  1  1=continuous, 0=one-shot
- cfg_en  in  1  requested run enable
- counter  in  CW  main counter value
- irq_ack  in  1  one-cycle interrupt acknowledge
- period_reg  out  CW  active period to counter
- duty_reg  out  CW  active duty to PWM core
- counter_en  out  1  counter run enable
- mode  out  1  active mode
- timer_mode  out  1  active timer mode
- irq_rst  out  1  0 = re-arm one-shot flag in counter
- irq  out  1  interrupt request, level
- upd_pend  out  1  shadow update waiting
- cfg_err  out  1  one-cycle pulse: rejected write
- state  out  2  FSM state

Function
REQ-003 SHALL hold shadow copies of all cfg_* fields, loaded on cfg_wr when cfg_period != 0; upd_pend set the same edge.
REQ-004 SHALL ignore cfg_wr with cfg_period == 0, leave shadows unchanged, and pulse cfg_err for 1 cycle.
REQ-005 SHALL have states IDLE=0, RUN=1, DONE=2; 3 SHALL return to IDLE.
REQ-006 IDLE: counter_en=0; pending update applies on next edge; cfg_en=1 in applied config -> RUN.
REQ-007 RUN, boundary = (mode=1 and counter == period_reg-1) or (mode=0 and counter >= period_reg).
REQ-008 RUN: pending update SHALL apply only on boundary edge; upd_pend clears on same edge.
REQ-009 RUN: applied cfg_en=0 -> IDLE on boundary edge, counter_en low the following cycle.
REQ-010 RUN, timer mode, boundary: irq set next edge; if timer_mode=0 -> DONE with counter_en=0.
REQ-011 DONE: counter_en=0; irq_ack -> irq_rst low 1 cycle; pending update with cfg_en=1 -> RUN, else IDLE.
REQ-012 irq SHALL stay high until irq_ack; simultaneous set and ack -> irq stays high.
REQ-013 irq_rst SHALL be 1 except the single cycle after irq_ack.
REQ-014 cfg_wr while upd_pend=1 SHALL overwrite shadows; last write wins.
REQ-015 mode change PWM->timer SHALL apply only at boundary, never mid-period.
REQ-016 Comparisons SHALL be unsigned CW-bit; period_reg-1 never underflows (period_reg != 0 guaranteed).

Reset
REQ-017 rst (async) and sw_rst (sync) SHALL force: state=IDLE, period_reg=1, duty_reg=0, counter_en=0, mode=0, timer_mode=0, irq=0, irq_rst=1, upd_pend=0, cfg_err=0, shadows cleared (period shadow=1).
REQ-018 Reset mid-RUN SHALL discard pending updates and pending irq.

Configuration
REQ-019 Macro TSC_IRQ_OVERRUN_EN: when defined, add output irq_ovr[7:0], saturating count of irq set events while irq already high, cleared on irq_ack; when undefined, port and logic absent.

Structure
REQ-020 Package timer_pkg SHALL hold state encodings (ST_IDLE, ST_RUN, ST_DONE), CW default and reset period constant.
REQ-021 Shadow storage and apply logic SHALL be sub-module tsc_shadow_regs; FSM and irq in top.

Verification
REQ-022 PWM update: period 10 running, cfg_wr period 20 at counter=3 -> period_reg stays 10 until counter=9 edge, then 20; upd_pend 1->0.
REQ-023 One-shot: timer, tmode=0, period 5, en=1 -> irq high after counter reaches 5, state=DONE, counter_en=0; irq_ack -> irq=0, irq_rst low exactly 1 cycle.
REQ-024 Rejected write: cfg_wr period 0 -> cfg_err 1-cycle pulse, period_reg and upd_pend unchanged.
REQ-025 Simultaneous: continuous timer period 3, irq_ack on same edge as new boundary -> irq remains 1; with TSC_IRQ_OVERRUN_EN, irq_ovr unchanged, without ack second boundary -> irq_ovr=1.
REQ-026 Reset mid-run: RUN, upd_pend=1, assert rst -> all outputs at reset values immediately; sw_rst same at next edge.
